mem_responder: RTL and testbench

- Memory-side responder for the multicycle processor's memory port. Services the controller's read and write requests.
- Ordinary addresses are forwarded to an external synchronous SRAM with a programmable number of wait states.
- One address (IO_ADDR) is decoded to a local I/O register and completes on the fast path.
- Reports completion with a one-cycle done pulse and a registered read-data word.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 135 +++++++++++++
 tb/tb_mem_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Processor-side memory request/response bundle shared by the controller and the responder.
interface mem_responder_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              busy;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, done, busy
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, done, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: forwards requests to a wait-stated synchronous SRAM, or serves a single
// memory-mapped I/O register on a one-cycle fast path.
module mem_responder #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = 8'hFF
) (
    input  logic              clock,
    input  logic              reset,
    mem_responder_if.slave    bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_en,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              err
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StDone   = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic              op_q, op_d;  // 1 = write
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] io_q, io_d;
    logic              err_q, err_d;

    logic req, accept, is_io;

    always_comb begin
        req     = bus.mem_read | bus.mem_write;
        accept  = (state_q == StIdle) && armed_q && req;
        is_io   = (bus.addr == IO_ADDR);

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        io_d    = io_q;
        err_d   = err_q;
        // Re-arm only once the requester has dropped its level, so a held request runs once.
        armed_d = req ? (accept ? 1'b0 : armed_q) : 1'b1;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    op_d    = ~bus.mem_read;
                    if (bus.mem_read && bus.mem_write) begin
                        err_d = 1'b1;
                    end
                    if (is_io) begin
                        state_d = StDone;
                        if (bus.mem_read) begin
                            rdata_d = io_in;
                        end else begin
                            io_d = bus.wdata;
                        end
                    end else begin
                        cnt_d   = WaitLoad;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    if (!op_q) begin
                        rdata_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            armed_q <= 1'b1;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            io_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            io_q    <= io_d;
            err_q   <= err_d;
        end
    end

    // SRAM controls decode from registered state only, so reset clears them asynchronously.
    assign sram_en    = (state_q == StAccess);
    assign sram_we    = sram_en & op_q;
    assign sram_addr  = sram_en ? addr_q : '0;
    assign sram_wdata = sram_en ? wdata_q : '0;

    assign bus.done  = (state_q == StDone);
    assign bus.busy  = (state_q == StAccess) || (state_q == StDone);
    assign bus.rdata = rdata_q;
    assign io_out    = io_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, multi-cycle corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_mem_responder;

    localparam int          W  = 2;
    localparam logic [7:0]  IO = 8'hFF;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] sram_addr, sram_wdata, sram_rdata, io_in, io_out;
    logic       sram_en, sram_we, err;

    mem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus_if ();

    mem_responder #(
        .DATA_W(8), .ADDR_W(8), .WAIT_STATES(W), .IO_ADDR(IO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus_if),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_rdata (sram_rdata),
        .io_in      (io_in),
        .io_out     (io_out),
        .err        (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model state
    logic [7:0] m_rdata, m_io;
    logic       m_err;

    typedef struct {
        logic       rd, wr;
        logic [7:0] a, wd, srd, ioi;
        int         lat, en_cyc;
        logic [7:0] rdata, io;
        logic       err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one request from cycle 0, observe until done, then drop the level.
    task automatic run_txn(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] srd, input logic [7:0] ioi,
                           output int lat, output int en_cyc, output int bad_bus);
        @(negedge clock);
        bus_if.mem_read  = rd;
        bus_if.mem_write = wr;
        bus_if.addr      = a;
        bus_if.wdata     = wd;
        sram_rdata       = srd;
        io_in            = ioi;
        lat = 0; en_cyc = 0; bad_bus = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (sram_en) begin
                en_cyc++;
                if (sram_we !== (wr && !rd) || sram_addr !== a || sram_wdata !== wd) bad_bus++;
            end else if (sram_we !== 1'b0 || sram_addr !== 8'h00 || sram_wdata !== 8'h00) begin
                bad_bus++;
            end
            if (bus_if.done) begin
                lat = c;
                break;
            end
        end
        bus_if.mem_read  = 1'b0;
        bus_if.mem_write = 1'b0;
        @(negedge clock);
        check("done_single_pulse", {30'd0, bus_if.done, bus_if.busy}, 32'd0);
    endtask

    task automatic apply(input string tag, input vec_t v);
        int lat, en_cyc, bad;
        run_txn(v.rd, v.wr, v.a, v.wd, v.srd, v.ioi, lat, en_cyc, bad);
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_sram_cycles"}, en_cyc, v.en_cyc);
        check({tag, "_sram_bus"}, bad, 0);
        check({tag, "_rdata"}, bus_if.rdata, v.rdata);
        check({tag, "_io_out"}, io_out, v.io);
        check({tag, "_err"}, err, v.err);
    endtask

    // Expected outcome from the request alone and the model's history.
    task automatic predict(inout vec_t v);
        logic io_hit;
        io_hit = (v.a == IO);
        if (v.rd && v.wr) m_err = 1'b1;
        v.lat    = io_hit ? 1 : W + 2;
        v.en_cyc = io_hit ? 0 : W + 1;
        if (v.rd) m_rdata = io_hit ? v.ioi : v.srd;
        else if (io_hit) m_io = v.wd;
        v.rdata = m_rdata;
        v.io    = m_io;
        v.err   = m_err;
    endtask

    vec_t tbl[7];

    initial begin
        int dones, n;
        vec_t v;

        tbl[0] = '{1, 0, 8'h10, 8'h00, 8'hA5, 8'h00, 4, 3, 8'hA5, 8'h00, 0};
        tbl[1] = '{0, 1, 8'h22, 8'h3C, 8'h77, 8'h00, 4, 3, 8'hA5, 8'h00, 0};
        tbl[2] = '{0, 1, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 8'hA5, 8'h5A, 0};
        tbl[3] = '{1, 0, 8'hFF, 8'h00, 8'h00, 8'hC3, 1, 0, 8'hC3, 8'h5A, 0};
        tbl[4] = '{1, 1, 8'h10, 8'h99, 8'h4E, 8'h00, 4, 3, 8'h4E, 8'h5A, 1};
        tbl[5] = '{0, 1, 8'h30, 8'h11, 8'h00, 8'h00, 4, 3, 8'h4E, 8'h5A, 1};
        tbl[6] = '{1, 0, 8'hFF, 8'h00, 8'h00, 8'h0F, 1, 0, 8'h0F, 8'h5A, 1};

        reset = 1'b1;
        bus_if.mem_read = 0; bus_if.mem_write = 0; bus_if.addr = 0; bus_if.wdata = 0;
        sram_rdata = 0; io_in = 0;
        #2;
        check("reset_outputs",
              {bus_if.rdata, io_out, sram_addr, sram_wdata}, 32'd0);
        check("reset_flags", {27'd0, bus_if.done, bus_if.busy, sram_en, sram_we, err}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_after_reset", {30'd0, bus_if.busy, sram_en}, 32'd0);

        for (int i = 0; i < 7; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Held read level must be serviced exactly once until dropped.
        @(negedge clock);
        bus_if.mem_read = 1; bus_if.addr = 8'h40; sram_rdata = 8'h66;
        dones = 0;
        for (int c = 1; c <= W + 12; c++) begin
            @(negedge clock);
            if (bus_if.done) dones++;
        end
        check("held_single_done", dones, 1);
        check("held_rdata", bus_if.rdata, 8'h66);
        bus_if.mem_read = 0;
        @(negedge clock);
        bus_if.mem_read = 1; sram_rdata = 8'h67;
        dones = 0;
        for (int c = 1; c <= W + 4; c++) begin
            @(negedge clock);
            if (bus_if.done) dones++;
        end
        check("rearm_second_done", dones, 1);
        check("rearm_rdata", bus_if.rdata, 8'h67);
        bus_if.mem_read = 0;
        @(negedge clock);

        // Reset in cycle 2 of an SRAM read aborts it.
        @(negedge clock);
        bus_if.mem_read = 1; bus_if.addr = 8'h50; sram_rdata = 8'h12;
        @(negedge clock);
        @(negedge clock);
        check("pre_reset_sram_en", sram_en, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_async_drop", {29'd0, sram_en, bus_if.busy, bus_if.done}, 32'd0);
        bus_if.mem_read = 0;
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (bus_if.done || sram_en) dones++;
        end
        check("abort_no_activity", dones, 0);
        reset = 1'b0;
        m_rdata = 0; m_io = 0; m_err = 0;
        check("abort_state_cleared", {15'd0, bus_if.rdata, io_out, err}, 32'd0);
        v = '{1, 0, 8'h50, 8'h00, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00, 0};
        predict(v);
        apply("post_reset_read", v);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 9);
            v.rd  = (n < 4) || (n >= 8);
            v.wr  = (n >= 4);
            v.a   = ($urandom_range(0, 3) == 0) ? IO : 8'($urandom_range(0, 254));
            v.wd  = 8'($urandom);
            v.srd = 8'($urandom);
            v.ioi = 8'($urandom);
            predict(v);
            apply($sformatf("rand%0d", i), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
